// File: rtl/rtu_rsp_queue.sv
// Response queue between the RTU lookup engine and swc_core: buffers lookup results
// and presents them first-word-fall-through with the rtu_rsp_valid/rtu_rsp_ack handshake.
module rtu_rsp_queue #(
    parameter int unsigned g_num_ports            = 11,
    parameter int unsigned g_prio_width           = 3,
    parameter int unsigned g_depth                = 4,
    parameter int unsigned g_force_drop_zero_mask = 1
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [g_num_ports-1:0]        req_dst_port_mask_i,
    input  logic                          req_drop_i,
    input  logic [g_prio_width-1:0]       req_prio_i,
    output logic                          rtu_rsp_valid_o,
    input  logic                          rtu_rsp_ack_i,
    output logic [g_num_ports-1:0]        rtu_dst_port_mask_o,
    output logic                          rtu_drop_o,
    output logic [g_prio_width-1:0]       rtu_prio_o,
    output logic [$clog2(g_depth):0]      count_o,
    output logic                          overflow_o
);

    localparam int unsigned PTR_W = $clog2(g_depth);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [g_num_ports-1:0]  mask;
        logic                    drop;
        logic [g_prio_width-1:0] prio;
    } entry_t;

    entry_t           mem [g_depth];
    entry_t           wdata;
    entry_t           head;
    entry_t           head_nxt;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic             ready;
    logic             ready_nxt;
    logic             valid;
    logic             valid_nxt;
    logic             overflow;
    logic             overflow_nxt;
    logic             wr_en;
    logic             rd_en;

    // Next-state computation for pointers, occupancy and the registered head.
    always_comb begin
        wr_en        = req_valid_i & ready;
        rd_en        = rtu_rsp_ack_i & valid;

        wdata.mask   = req_dst_port_mask_i;
        wdata.prio   = req_prio_i;
        wdata.drop   = req_drop_i |
                       ((g_force_drop_zero_mask != 0) && (req_dst_port_mask_i == '0));

        wr_ptr_nxt   = wr_en ? wr_ptr + PTR_W'(1) : wr_ptr;
        rd_ptr_nxt   = rd_en ? rd_ptr + PTR_W'(1) : rd_ptr;

        count_nxt    = count;
        case ({wr_en, rd_en})
            2'b10:   count_nxt = count + CNT_W'(1);
            2'b01:   count_nxt = count - CNT_W'(1);
            default: count_nxt = count;
        endcase

        ready_nxt    = count_nxt < CNT_W'(g_depth);
        valid_nxt    = count_nxt != '0;
        overflow_nxt = req_valid_i & ~ready;

        // Head keeps its last value when the queue drains; a write landing in the
        // slot about to become head bypasses the storage array.
        head_nxt     = head;
        if (count_nxt != '0) begin
            if (wr_en && (rd_ptr_nxt == wr_ptr)) begin
                head_nxt = wdata;
            end else begin
                head_nxt = mem[rd_ptr_nxt];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ready    <= 1'b1;
            valid    <= 1'b0;
            overflow <= 1'b0;
            head     <= '0;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt;
            count    <= count_nxt;
            ready    <= ready_nxt;
            valid    <= valid_nxt;
            overflow <= overflow_nxt;
            head     <= head_nxt;
        end
    end

    assign req_ready_o         = ready;
    assign rtu_rsp_valid_o     = valid;
    assign rtu_dst_port_mask_o = head.mask;
    assign rtu_drop_o          = head.drop;
    assign rtu_prio_o          = head.prio;
    assign count_o             = count;
    assign overflow_o          = overflow;

endmodule

// File: tb/tb_rtu_rsp_queue.sv
// Directed bench for rtu_rsp_queue with hand-computed expectations.
module tb_rtu_rsp_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [10:0] req_mask;
    logic        req_drop;
    logic [2:0]  req_prio;
    logic        rsp_valid;
    logic        rsp_ack;
    logic [10:0] rsp_mask;
    logic        rsp_drop;
    logic [2:0]  rsp_prio;
    logic [2:0]  count;
    logic        overflow;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rtu_rsp_queue #(
        .g_num_ports(11),
        .g_prio_width(3),
        .g_depth(4),
        .g_force_drop_zero_mask(1)
    ) dut (
        .clk_i(clk),
        .rst_n_i(rst_n),
        .req_valid_i(req_valid),
        .req_ready_o(req_ready),
        .req_dst_port_mask_i(req_mask),
        .req_drop_i(req_drop),
        .req_prio_i(req_prio),
        .rtu_rsp_valid_o(rsp_valid),
        .rtu_rsp_ack_i(rsp_ack),
        .rtu_dst_port_mask_o(rsp_mask),
        .rtu_drop_o(rsp_drop),
        .rtu_prio_o(rsp_prio),
        .count_o(count),
        .overflow_o(overflow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [10:0] m, input logic d, input logic [2:0] p);
        req_valid = 1'b1;
        req_mask  = m;
        req_drop  = d;
        req_prio  = p;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_mask  = '0;
        req_drop  = 1'b0;
        req_prio  = '0;
        rsp_ack   = 1'b0;

        // 1: reset held three clocks
        repeat (3) step();
        chk("rst_valid", 32'(rsp_valid), 0);
        chk("rst_ready", 32'(req_ready), 1);
        chk("rst_count", 32'(count), 0);
        chk("rst_mask", 32'(rsp_mask), 0);
        chk("rst_drop", 32'(rsp_drop), 0);
        chk("rst_prio", 32'(rsp_prio), 0);
        chk("rst_ovf", 32'(overflow), 0);
        rst_n = 1'b1;
        step();

        // 2: single write, one-cycle latency, then ack
        wr(11'h001, 1'b0, 3'd2);
        step();
        req_valid = 1'b0;
        chk("t2_valid", 32'(rsp_valid), 1);
        chk("t2_mask", 32'(rsp_mask), 32'h001);
        chk("t2_prio", 32'(rsp_prio), 2);
        chk("t2_drop", 32'(rsp_drop), 0);
        chk("t2_count", 32'(count), 1);
        rsp_ack = 1'b1;
        step();
        rsp_ack = 1'b0;
        chk("t2_valid_after_ack", 32'(rsp_valid), 0);
        chk("t2_count_after_ack", 32'(count), 0);
        chk("t2_mask_held", 32'(rsp_mask), 32'h001);

        // 3: five back-to-back writes into depth 4
        for (int i = 1; i <= 4; i++) begin
            wr(11'h010, 1'b0, 3'(i));
            step();
        end
        chk("t3_count_full", 32'(count), 4);
        chk("t3_ready_full", 32'(req_ready), 0);
        chk("t3_ovf_before", 32'(overflow), 0);
        wr(11'h010, 1'b0, 3'd5);
        step();
        req_valid = 1'b0;
        chk("t3_ovf_pulse", 32'(overflow), 1);
        chk("t3_count_still", 32'(count), 4);
        step();
        chk("t3_ovf_clear", 32'(overflow), 0);
        for (int i = 1; i <= 4; i++) begin
            chk("t3_head_valid", 32'(rsp_valid), 1);
            chk("t3_head_prio", 32'(rsp_prio), 32'(i));
            rsp_ack = 1'b1;
            step();
        end
        rsp_ack = 1'b0;
        chk("t3_drained_valid", 32'(rsp_valid), 0);
        chk("t3_drained_count", 32'(count), 0);
        chk("t3_ready_again", 32'(req_ready), 1);

        // 4: simultaneous write and ack at count 2
        wr(11'h002, 1'b0, 3'd1);
        step();
        wr(11'h002, 1'b0, 3'd2);
        step();
        chk("t4_count2", 32'(count), 2);
        wr(11'h004, 1'b0, 3'd7);
        rsp_ack = 1'b1;
        step();
        req_valid = 1'b0;
        chk("t4_count_same", 32'(count), 2);
        chk("t4_head_oldest", 32'(rsp_prio), 2);
        step();
        chk("t4_head_new", 32'(rsp_prio), 7);
        chk("t4_mask_new", 32'(rsp_mask), 32'h004);
        step();
        rsp_ack = 1'b0;
        chk("t4_empty", 32'(count), 0);

        // 4b: pointer wrap over ten write/ack cycles at occupancy 1
        wr(11'h001, 1'b1, 3'd0);
        step();
        chk("t4w_drop_verbatim", 32'(rsp_drop), 1);
        for (int i = 1; i <= 9; i++) begin
            wr(11'(i + 1), 1'b0, 3'(i));
            rsp_ack = 1'b1;
            step();
            chk("t4w_count", 32'(count), 1);
            chk("t4w_prio", 32'(rsp_prio), 32'(i & 7));
            chk("t4w_mask", 32'(rsp_mask), 32'(i + 1));
        end
        req_valid = 1'b0;
        step();
        rsp_ack = 1'b0;
        chk("t4w_empty", 32'(count), 0);
        chk("t4w_valid", 32'(rsp_valid), 0);

        // 5: zero mask forces drop; ack while empty is ignored
        wr(11'h000, 1'b0, 3'd3);
        step();
        req_valid = 1'b0;
        chk("t5_drop_forced", 32'(rsp_drop), 1);
        chk("t5_mask_zero", 32'(rsp_mask), 0);
        chk("t5_prio", 32'(rsp_prio), 3);
        rsp_ack = 1'b1;
        step();
        chk("t5_count0", 32'(count), 0);
        step();
        rsp_ack = 1'b0;
        chk("t5_underflow_count", 32'(count), 0);
        chk("t5_underflow_valid", 32'(rsp_valid), 0);

        // 6: reset mid-operation flushes entries
        for (int i = 1; i <= 3; i++) begin
            wr(11'h100, 1'b0, 3'(i));
            step();
        end
        req_valid = 1'b0;
        chk("t6_count3", 32'(count), 3);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t6_rst_count", 32'(count), 0);
        chk("t6_rst_valid", 32'(rsp_valid), 0);
        chk("t6_rst_prio", 32'(rsp_prio), 0);
        step();
        wr(11'h080, 1'b0, 3'd6);
        step();
        req_valid = 1'b0;
        chk("t6_prio6", 32'(rsp_prio), 6);
        chk("t6_count1", 32'(count), 1);
        rsp_ack = 1'b1;
        step();
        rsp_ack = 1'b0;
        chk("t6_final_valid", 32'(rsp_valid), 0);
        chk("t6_final_count", 32'(count), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
